// File: rtl/ft245_device.sv
// Device side of an FT245-style asynchronous byte-FIFO port: answers host rd_n/wr_n
// strobes from an IN FIFO (to host) and into an OUT FIFO (from host).
module ft245_device #(
  parameter int DEPTH    = 16,
  parameter int RXF_HOLD = 2,
  parameter int TXE_HOLD = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pad_rd_n,
  input  logic                    pad_wr_n,
  input  logic [7:0]              pad_data_i,
  output logic [7:0]              pad_data_o,
  output logic                    pad_data_oe,
  output logic                    pad_rxf_n,
  output logic                    pad_txe_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  in_level,
  output logic [$clog2(DEPTH):0]  out_level,
  output logic                    rd_err,
  output logic                    wr_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int RHW = $clog2(RXF_HOLD + 1);
  localparam int THW = $clog2(TXE_HOLD + 1);

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_RELEASE
  } rd_state_t;

  // Registered pad inputs and their previous values for edge detection.
  logic            r_rd_q, r_rd_p;
  logic            r_wr_q, r_wr_p;
  logic [7:0]      r_din_q;
  logic            r_live;

  logic [7:0]      r_in_mem  [DEPTH];
  logic [7:0]      r_out_mem [DEPTH];
  logic [AW:0]     r_in_wptr, r_in_rptr;
  logic [AW:0]     r_out_wptr, r_out_rptr;

  rd_state_t       r_state;
  logic [7:0]      r_data_o;
  logic            r_data_oe;
  logic [RHW-1:0]  r_rxf_hold;
  logic [THW-1:0]  r_txe_hold;
  logic            r_rd_err, r_wr_err;

  logic w_in_empty, w_in_full, w_out_empty, w_out_full;
  logic w_in_push, w_in_pop, w_out_push, w_out_pop;
  logic w_rd_fall, w_rd_rise, w_wr_fall;
  logic w_rxf_n, w_txe_n;

  assign w_in_empty  = (r_in_wptr == r_in_rptr);
  assign w_in_full   = (r_in_wptr[AW] != r_in_rptr[AW]) &&
                       (r_in_wptr[AW-1:0] == r_in_rptr[AW-1:0]);
  assign w_out_empty = (r_out_wptr == r_out_rptr);
  assign w_out_full  = (r_out_wptr[AW] != r_out_rptr[AW]) &&
                       (r_out_wptr[AW-1:0] == r_out_rptr[AW-1:0]);

  assign w_rd_fall = r_rd_p & ~r_rd_q;
  assign w_rd_rise = ~r_rd_p & r_rd_q;
  assign w_wr_fall = r_wr_p & ~r_wr_q;

  // Flags are held off during RELEASE and while the post-transfer hold counts down.
  assign w_rxf_n = ~(~w_in_empty && (r_rxf_hold == '0) && (r_state != RD_RELEASE));
  assign w_txe_n = ~(r_live && ~w_out_full && (r_txe_hold == '0));

  assign w_in_push  = in_valid & ~w_in_full;
  assign w_in_pop   = (r_state == RD_READ) & w_rd_rise;
  assign w_out_push = w_wr_fall & ~w_txe_n;
  assign w_out_pop  = ~w_out_empty & out_ready;

  assign pad_data_o  = r_data_o;
  assign pad_data_oe = r_data_oe;
  assign pad_rxf_n   = w_rxf_n;
  assign pad_txe_n   = w_txe_n;
  assign in_ready    = ~w_in_full;
  assign out_data    = r_out_mem[r_out_rptr[AW-1:0]];
  assign out_valid   = ~w_out_empty;
  assign in_level    = r_in_wptr - r_in_rptr;
  assign out_level   = r_out_wptr - r_out_rptr;
  assign rd_err      = r_rd_err;
  assign wr_err      = r_wr_err;

  // NOTE: storage has no reset; the pointers alone decide which entries are valid,
  // so the arrays can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_in_push)  r_in_mem[r_in_wptr[AW-1:0]]   <= in_data;
    if (w_out_push) r_out_mem[r_out_wptr[AW-1:0]] <= r_din_q;
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_q     <= 1'b1;
      r_rd_p     <= 1'b1;
      r_wr_q     <= 1'b1;
      r_wr_p     <= 1'b1;
      r_din_q    <= 8'h00;
      r_live     <= 1'b0;
      r_in_wptr  <= '0;
      r_in_rptr  <= '0;
      r_out_wptr <= '0;
      r_out_rptr <= '0;
    end else begin
      r_rd_q  <= pad_rd_n;
      r_rd_p  <= r_rd_q;
      r_wr_q  <= pad_wr_n;
      r_wr_p  <= r_wr_q;
      r_din_q <= pad_data_i;
      r_live  <= 1'b1;
      if (w_in_push)  r_in_wptr  <= r_in_wptr + (AW+1)'(1);
      if (w_in_pop)   r_in_rptr  <= r_in_rptr + (AW+1)'(1);
      if (w_out_push) r_out_wptr <= r_out_wptr + (AW+1)'(1);
      if (w_out_pop)  r_out_rptr <= r_out_rptr + (AW+1)'(1);
    end
  end

  // Host read FSM; the bus byte is latched once at IDLE->READ so later pushes cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RD_IDLE;
      r_data_o   <= 8'h00;
      r_data_oe  <= 1'b0;
      r_rxf_hold <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      if (w_in_pop)
        r_rxf_hold <= RHW'(RXF_HOLD);
      else if (r_rxf_hold != '0)
        r_rxf_hold <= r_rxf_hold - RHW'(1);

      if (w_rd_fall && w_rxf_n)
        r_rd_err <= 1'b1;

      case (r_state)
        RD_IDLE: begin
          if (w_rd_fall && !w_rxf_n) begin
            r_state   <= RD_READ;
            r_data_oe <= 1'b1;
            r_data_o  <= r_in_mem[r_in_rptr[AW-1:0]];
          end
        end
        RD_READ: begin
          if (w_rd_rise) begin
            r_state   <= RD_RELEASE;
            r_data_oe <= 1'b0;
          end
        end
        RD_RELEASE: begin
          r_state   <= RD_IDLE;
          r_data_oe <= 1'b0;
        end
        default: begin
          r_state   <= RD_IDLE;
          r_data_oe <= 1'b0;
        end
      endcase
    end
  end

  // Host write side: one push per falling edge, then txe_n held off for TXE_HOLD cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_txe_hold <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      if (w_out_push)
        r_txe_hold <= THW'(TXE_HOLD);
      else if (r_txe_hold != '0)
        r_txe_hold <= r_txe_hold - THW'(1);

      if (w_wr_fall && w_txe_n)
        r_wr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ft245_device.sv
// Scoreboard bench for ft245_device: queue-based model of both FIFOs, directed
// scenarios followed by randomized host/stream traffic.
`timescale 1ns/1ps
module tb_ft245_device;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk, rst_n;
  logic          pad_rd_n, pad_wr_n;
  logic [7:0]    pad_data_i, pad_data_o;
  logic          pad_data_oe, pad_rxf_n, pad_txe_n;
  logic [7:0]    in_data, out_data;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [LW-1:0] in_level, out_level;
  logic          rd_err, wr_err;

  ft245_device #(.DEPTH(DEPTH), .RXF_HOLD(2), .TXE_HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .pad_rd_n(pad_rd_n), .pad_wr_n(pad_wr_n),
    .pad_data_i(pad_data_i), .pad_data_o(pad_data_o), .pad_data_oe(pad_data_oe),
    .pad_rxf_n(pad_rxf_n), .pad_txe_n(pad_txe_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_level(in_level), .out_level(out_level),
    .rd_err(rd_err), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model_in[$];
  logic [7:0] rd_exp[$];
  logic [7:0] out_exp[$];
  logic       exp_wr_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: bus bytes and stream pops are compared against their queues.
  logic [7:0] held_byte = 8'h00;
  logic       oe_prev   = 1'b0;
  always @(negedge clk) begin
    if (pad_data_oe && !oe_prev) begin
      if (rd_exp.size() == 0) begin
        check("bus_unexpected_oe", pad_data_oe, 0);
        held_byte = pad_data_o;
      end else begin
        held_byte = rd_exp.pop_front();
        check("bus_byte", pad_data_o, held_byte);
      end
    end else if (pad_data_oe) begin
      check("bus_stable", pad_data_o, held_byte);
    end
    oe_prev = pad_data_oe;
    if (out_valid && out_ready) begin
      if (out_exp.size() == 0) check("out_unexpected", out_valid, 0);
      else                     check("out_byte", out_data, out_exp.pop_front());
    end
  end

  task automatic in_push(input logic [7:0] d);
    check("in_ready", in_ready, model_in.size() < DEPTH);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (model_in.size() < DEPTH) model_in.push_back(d);
  endtask

  task automatic rd_begin();
    rd_exp.push_back(model_in.pop_front());
    pad_rd_n = 1'b0;
    tick();
    check("rd_oe_early", pad_data_oe, 0);
    tick();
    check("rd_oe", pad_data_oe, 1);
  endtask

  task automatic rd_end();
    pad_rd_n = 1'b1;
    tick();
    check("rd_oe_held", pad_data_oe, 1);
    tick();
    check("rd_oe_release", pad_data_oe, 0);
    check("rd_rxf_hold1", pad_rxf_n, 1);
    check("rd_level", in_level, model_in.size());
    tick();
    check("rd_rxf_hold2", pad_rxf_n, 1);
  endtask

  task automatic host_write(input logic [7:0] d, input int low, input logic ok);
    pad_data_i = d;
    pad_wr_n   = 1'b0;
    tick();
    tick();
    check("wr_txe_busy", pad_txe_n, 1);
    if (!ok) exp_wr_err = 1'b1;
    check("wr_err", wr_err, exp_wr_err);
    if (ok) out_exp.push_back(d);
    repeat (low - 2) tick();
    pad_wr_n   = 1'b1;
    pad_data_i = ~d;
    tick();
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n = 1'b0; pad_rd_n = 1'b1; pad_wr_n = 1'b1; pad_data_i = 8'h00;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;

    // Reset state and first cycle after release.
    tick(); tick();
    check("rst_txe", pad_txe_n, 1);
    check("rst_rxf", pad_rxf_n, 1);
    check("rst_oe", pad_data_oe, 0);
    check("rst_data", pad_data_o, 0);
    check("rst_in_level", in_level, 0);
    check("rst_out_level", out_level, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_txe", pad_txe_n, 0);
    check("post_rst_rxf", pad_rxf_n, 1);
    check("post_rst_oe", pad_data_oe, 0);

    // Two reads separated by a 3-cycle gap.
    in_push(8'hA5);
    in_push(8'h3C);
    check("in_level_2", in_level, 2);
    rd_begin(); tick(); tick(); rd_end();
    rd_begin(); tick(); tick(); rd_end();
    tick();
    check("rxf_empty", pad_rxf_n, 1);

    // Fill OUT FIFO, overflow write, then drain in order.
    for (int i = 0; i < DEPTH; i++) host_write(8'h11 + 8'(i), 2, 1'b1);
    check("out_full_level", out_level, DEPTH);
    check("out_full_txe", pad_txe_n, 1);
    host_write(8'hEE, 2, 1'b0);
    check("overflow_level", out_level, DEPTH);
    out_ready = 1'b1;
    cnt = 0;
    while (out_exp.size() != 0 && cnt < 64) begin tick(); cnt++; end
    check("drain_left", out_exp.size(), 0);
    tick();
    check("drain_level", out_level, 0);
    check("drain_txe", pad_txe_n, 0);
    out_ready = 1'b0;

    // Push during an active read must not disturb the driven byte.
    in_push(8'h55);
    rd_begin();
    tick();
    in_push(8'h77);
    tick();
    rd_end();
    tick();
    check("rxf_after_hold", pad_rxf_n, 0);
    rd_begin(); tick(); rd_end();

    // Read strobe with IN FIFO empty.
    tick(); tick();
    check("rd_err_clear", rd_err, 0);
    pad_rd_n = 1'b0;
    tick(); tick(); tick();
    check("rd_err_set", rd_err, 1);
    check("rd_err_oe", pad_data_oe, 0);
    check("rd_err_level", in_level, 0);
    pad_rd_n = 1'b1;
    tick(); tick();

    // Reset in the middle of a read with three bytes queued.
    in_push(8'hA1); in_push(8'hB2); in_push(8'hC3);
    rd_begin();
    tick();
    rst_n = 1'b0; pad_rd_n = 1'b1;
    tick();
    check("mid_rst_oe", pad_data_oe, 0);
    check("mid_rst_level", in_level, 0);
    check("mid_rst_rxf", pad_rxf_n, 1);
    check("mid_rst_rd_err", rd_err, 0);
    check("mid_rst_wr_err", wr_err, 0);
    check("mid_rst_txe", pad_txe_n, 1);
    model_in.delete();
    exp_wr_err = 1'b0;
    rst_n = 1'b1;
    tick();
    check("mid_rst_txe_up", pad_txe_n, 0);

    // Randomized traffic.
    for (int it = 0; it < 150; it++) begin
      out_ready = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: if (model_in.size() < DEPTH) in_push(8'($urandom));
        1: if (model_in.size() > 0) begin
             cnt = 0;
             while (pad_rxf_n && cnt < 8) begin tick(); cnt++; end
             check("rxf_wait", pad_rxf_n, 0);
             rd_begin();
             repeat ($urandom_range(0, 2)) tick();
             rd_end();
           end
        2: begin
             cnt = 0;
             while (pad_txe_n && cnt < 64) begin out_ready = 1'b1; tick(); cnt++; end
             check("txe_wait", pad_txe_n, 0);
             host_write(8'($urandom), $urandom_range(2, 4), 1'b1);
           end
        default: tick();
      endcase
      check("rand_in_level", in_level, model_in.size());
    end

    out_ready = 1'b1;
    cnt = 0;
    while (out_exp.size() != 0 && cnt < 64) begin tick(); cnt++; end
    check("final_out_left", out_exp.size(), 0);
    check("final_rd_left", rd_exp.size(), 0);
    check("final_rd_err", rd_err, 0);
    check("final_wr_err", wr_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
